// File: rtl/int_isq.sv
// Integer issue queue: buffers renamed instructions from dispatch, tracks per-source
// sleep bits, wakes entries on writeback broadcasts and issues the oldest ready entry.
// Storage is compacting: index 0 holds the oldest valid entry.
module int_isq #(
  parameter int DATA_WIDTH      = 248,
  parameter int CONDITION_WIDTH = 2,
  parameter int DEPTH           = 8,
  parameter int CNT_WIDTH       = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       disp2intisq_enq_valid,
  output logic                       intisq_can_enq,
  output logic                       intisq2disp_enq_ready,
  input  logic [DATA_WIDTH-1:0]      disp2intisq_instr0_enq_data,
  input  logic [CONDITION_WIDTH-1:0] disp2intisq_instr0_enq_condition,
  input  logic                       wb0_valid,
  input  logic [5:0]                 wb0_prd,
  input  logic                       wb1_valid,
  input  logic [5:0]                 wb1_prd,
  output logic                       intisq2exu_issue_valid,
  input  logic                       exu2intisq_issue_ready,
  output logic [DATA_WIDTH-1:0]      intisq2exu_issue_data,
  output logic [CNT_WIDTH-1:0]       intisq_count,
  input  logic                       flush_valid
);

  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PRS1_MSB  = 116;
  localparam int PRS1_LSB  = 111;
  localparam int PRS2_MSB  = 110;
  localparam int PRS2_LSB  = 105;
  localparam int SRC1_REG  = 104;
  localparam int SRC2_REG  = 103;

  logic [DEPTH-1:0]      valid_q, sleep1_q, sleep2_q;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [CNT_WIDTH-1:0]  count_q;

  logic [DEPTH-1:0]      valid_d, sleep1_d, sleep2_d;
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [CNT_WIDTH-1:0]  count_d;

  // Entry contents as seen from the slot above (used when shifting down on issue)
  logic [DEPTH-1:0]      up_valid, up_sleep1, up_sleep2;
  logic [DATA_WIDTH-1:0] up_data [DEPTH];

  logic [DEPTH-1:0]      wake1, wake2, ready;
  logic [IDX_W-1:0]      sel;
  logic                  any_ready;
  logic                  issue_fire, enq_fire, can_enq;
  logic                  enq_sleep1, enq_sleep2;
  logic [CNT_WIDTH-1:0]  widx;

  function automatic logic wb_hit(input logic [5:0] r, input logic v0, input logic [5:0] p0,
                                  input logic v1, input logic [5:0] p1);
    return (v0 && (p0 == r)) || (v1 && (p1 == r));
  endfunction

  // Wakeup matches, readiness and oldest-first selection
  always_comb begin
    wake1     = '0;
    wake2     = '0;
    ready     = '0;
    sel       = '0;
    any_ready = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wake1[i] = sleep1_q[i] && wb_hit(data_q[i][PRS1_MSB:PRS1_LSB], wb0_valid, wb0_prd, wb1_valid, wb1_prd);
      wake2[i] = sleep2_q[i] && wb_hit(data_q[i][PRS2_MSB:PRS2_LSB], wb0_valid, wb0_prd, wb1_valid, wb1_prd);
      ready[i] = valid_q[i] && !sleep1_q[i] && !sleep2_q[i];
    end
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (ready[i-1]) begin
        sel       = IDX_W'(i - 1);
        any_ready = 1'b1;
      end
    end
  end

  // Handshake outputs and enqueue-time sleep evaluation
  always_comb begin
    can_enq                = (count_q < CNT_WIDTH'(DEPTH)) && !flush_valid;
    intisq_can_enq         = can_enq;
    intisq2disp_enq_ready  = can_enq;
    intisq2exu_issue_valid = any_ready && !flush_valid;
    intisq2exu_issue_data  = any_ready ? data_q[sel] : '0;
    intisq_count           = count_q;
    issue_fire             = intisq2exu_issue_valid && exu2intisq_issue_ready;
    enq_fire               = disp2intisq_enq_valid && can_enq;
    enq_sleep1 = disp2intisq_instr0_enq_condition[0] && disp2intisq_instr0_enq_data[SRC1_REG] &&
                 !wb_hit(disp2intisq_instr0_enq_data[PRS1_MSB:PRS1_LSB], wb0_valid, wb0_prd, wb1_valid, wb1_prd);
    enq_sleep2 = disp2intisq_instr0_enq_condition[1] && disp2intisq_instr0_enq_data[SRC2_REG] &&
                 !wb_hit(disp2intisq_instr0_enq_data[PRS2_MSB:PRS2_LSB], wb0_valid, wb0_prd, wb1_valid, wb1_prd);
    widx = count_q - CNT_WIDTH'(issue_fire);
  end

  // Next state: wake in place, shift entries above the issued slot, append, flush
  always_comb begin
    up_valid  = '0;
    up_sleep1 = '0;
    up_sleep2 = '0;
    up_data   = data_q;
    for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
      up_valid[i]  = valid_q[i+1];
      up_sleep1[i] = sleep1_q[i+1] && !wake1[i+1];
      up_sleep2[i] = sleep2_q[i+1] && !wake2[i+1];
      up_data[i]   = data_q[i+1];
    end

    valid_d  = valid_q;
    sleep1_d = sleep1_q;
    sleep2_d = sleep2_q;
    data_d   = data_q;
    count_d  = count_q;

    // Wakeup is resolved at the pre-shift index, so sleep bits travel with their data
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (issue_fire && (IDX_W'(i) >= sel)) begin
        valid_d[i]  = up_valid[i];
        sleep1_d[i] = up_sleep1[i];
        sleep2_d[i] = up_sleep2[i];
        data_d[i]   = up_data[i];
      end else begin
        sleep1_d[i] = sleep1_q[i] && !wake1[i];
        sleep2_d[i] = sleep2_q[i] && !wake2[i];
      end
    end

    if (enq_fire) begin
      valid_d[widx[IDX_W-1:0]]  = 1'b1;
      sleep1_d[widx[IDX_W-1:0]] = enq_sleep1;
      sleep2_d[widx[IDX_W-1:0]] = enq_sleep2;
      data_d[widx[IDX_W-1:0]]   = disp2intisq_instr0_enq_data;
    end

    case ({enq_fire, issue_fire})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase

    if (flush_valid) begin
      valid_d  = '0;
      sleep1_d = '0;
      sleep2_d = '0;
      count_d  = '0;
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= '0;
      sleep1_q <= '0;
      sleep2_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      valid_q  <= valid_d;
      sleep1_q <= sleep1_d;
      sleep2_q <= sleep2_d;
      count_q  <= count_d;
      data_q   <= data_d;
    end
  end

  a_count_bound: assert property (@(posedge clock) disable iff (!reset_n)
    count_q <= CNT_WIDTH'(DEPTH));
  a_no_enq_full: assert property (@(posedge clock) disable iff (!reset_n)
    !(enq_fire && (count_q == CNT_WIDTH'(DEPTH))));

endmodule

// File: tb/tb_int_isq.sv
// Self-checking bench for int_isq: scenario tasks with inline checks plus an issue
// monitor that compares every issued payload against a scoreboard queue.
module tb_int_isq;

  localparam int DW = 248;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          enq_valid;
  logic          can_enq, enq_ready;
  logic [DW-1:0] enq_data;
  logic [1:0]    enq_cond;
  logic          wb0_valid, wb1_valid;
  logic [5:0]    wb0_prd, wb1_prd;
  logic          issue_valid, exu_ready;
  logic [DW-1:0] issue_data;
  logic [3:0]    count;
  logic          flush;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q [$];

  int_isq #(
    .DATA_WIDTH(DW),
    .CONDITION_WIDTH(2),
    .DEPTH(8),
    .CNT_WIDTH(4)
  ) dut (
    .clock                            (clock),
    .reset_n                          (reset_n),
    .disp2intisq_enq_valid            (enq_valid),
    .intisq_can_enq                   (can_enq),
    .intisq2disp_enq_ready            (enq_ready),
    .disp2intisq_instr0_enq_data      (enq_data),
    .disp2intisq_instr0_enq_condition (enq_cond),
    .wb0_valid                        (wb0_valid),
    .wb0_prd                          (wb0_prd),
    .wb1_valid                        (wb1_valid),
    .wb1_prd                          (wb1_prd),
    .intisq2exu_issue_valid           (issue_valid),
    .exu2intisq_issue_ready           (exu_ready),
    .intisq2exu_issue_data            (issue_data),
    .intisq_count                     (count),
    .flush_valid                      (flush)
  );

  always #5 clock = ~clock;

  // Issue monitor: every accepted issue must match the scoreboard head
  always @(negedge clock) begin
    if (reset_n === 1'b1 && issue_valid === 1'b1 && exu_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got robid %0d, expected no issue", issue_data[247:241]);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (issue_data !== e) begin
          errors++;
          $display("FAIL issue_data: got robid %0d data %h, expected robid %0d data %h",
                   issue_data[247:241], issue_data[63:0], e[247:241], e[63:0]);
        end
      end
    end
  end

  function automatic logic [DW-1:0] mk(input logic [6:0] rob, input logic [5:0] p1,
                                       input logic [5:0] p2, input logic r1, input logic r2);
    logic [DW-1:0] d;
    d = '0;
    d[63:0]    = {$urandom(), $urandom()};
    d[247:241] = rob;
    d[129:124] = rob[5:0];
    d[116:111] = p1;
    d[110:105] = p2;
    d[104]     = r1;
    d[103]     = r2;
    return d;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    enq_valid = 1'b0; enq_data = '0; enq_cond = 2'b00;
    wb0_valid = 1'b0; wb0_prd = '0; wb1_valid = 1'b0; wb1_prd = '0;
    exu_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    for (n = 0; n < budget && exp_q.size() != 0; n++) @(posedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout: %0d entries still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (can_enq !== 1'b1) begin errors++; $display("FAIL reset_can_enq: got %b expected 1", can_enq); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready: got %b expected 1", enq_ready); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b expected 0", issue_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (issue_data !== '0) begin errors++; $display("FAIL reset_issue_data: got %h expected 0", issue_data[63:0]); end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] d;
    tick();
    d = mk(7'd5, 6'd0, 6'd0, 1'b0, 1'b0);
    enq_valid = 1'b1; enq_data = d; enq_cond = 2'b00; exu_ready = 1'b1;
    exp_q.push_back(d);
    @(negedge clock);
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL basic_same_cycle_issue: got %b expected 0", issue_valid); end
    tick();
    enq_valid = 1'b0;
    @(negedge clock);
    checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL basic_issue_valid: got %b expected 1", issue_valid); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL basic_count1: got %0d expected 1", count); end
    tick();
    @(negedge clock);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL basic_count0: got %0d expected 0", count); end
    wait_drain(5, "basic");
    idle();
  endtask

  task automatic test_wakeup();
    logic [DW-1:0] d;
    tick();
    d = mk(7'd10, 6'd12, 6'd0, 1'b1, 1'b0);
    enq_valid = 1'b1; enq_data = d; enq_cond = 2'b01; exu_ready = 1'b1;
    exp_q.push_back(d);
    tick();
    enq_valid = 1'b0;
    @(negedge clock);
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_asleep: got %b expected 0", issue_valid); end
    tick();
    wb0_valid = 1'b1; wb0_prd = 6'd12;
    @(negedge clock);
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_bcast_cycle: got %b expected 0", issue_valid); end
    tick();
    wb0_valid = 1'b0;
    @(negedge clock);
    checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL wake_after_wb: got %b expected 1", issue_valid); end
    wait_drain(5, "wake");

    // Both sources asleep, woken by the two ports in the same cycle
    d = mk(7'd11, 6'd3, 6'd4, 1'b1, 1'b1);
    enq_valid = 1'b1; enq_data = d; enq_cond = 2'b11;
    exp_q.push_back(d);
    tick();
    enq_valid = 1'b0;
    wb0_valid = 1'b1; wb0_prd = 6'd3; wb1_valid = 1'b1; wb1_prd = 6'd4;
    @(negedge clock);
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL dual_wake_early: got %b expected 0", issue_valid); end
    tick();
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    @(negedge clock);
    checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL dual_wake: got %b expected 1", issue_valid); end
    wait_drain(5, "dual_wake");

    // Busy condition on a non-register source never sleeps
    d = mk(7'd12, 6'd20, 6'd21, 1'b0, 1'b0);
    enq_valid = 1'b1; enq_data = d; enq_cond = 2'b11;
    exp_q.push_back(d);
    tick();
    enq_valid = 1'b0;
    @(negedge clock);
    checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL imm_src_no_sleep: got %b expected 1", issue_valid); end
    wait_drain(5, "imm_src");
    idle();
  endtask

  task automatic test_same_cycle_wake();
    logic [DW-1:0] d;
    tick();
    d = mk(7'd13, 6'd7, 6'd0, 1'b1, 1'b0);
    enq_valid = 1'b1; enq_data = d; enq_cond = 2'b01; exu_ready = 1'b1;
    wb1_valid = 1'b1; wb1_prd = 6'd7;
    exp_q.push_back(d);
    tick();
    enq_valid = 1'b0; wb1_valid = 1'b0;
    @(negedge clock);
    checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL enq_wake_same_cycle: got %b expected 1", issue_valid); end
    wait_drain(5, "enq_wake");

    // A broadcast on a different tag must not wake the new entry
    d = mk(7'd14, 6'd7, 6'd0, 1'b1, 1'b0);
    enq_valid = 1'b1; enq_data = d; enq_cond = 2'b01;
    wb1_valid = 1'b1; wb1_prd = 6'd8;
    tick();
    enq_valid = 1'b0; wb1_valid = 1'b0;
    @(negedge clock);
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL enq_wake_miss: got %b expected 0", issue_valid); end
    tick();
    wb0_valid = 1'b1; wb0_prd = 6'd7;
    exp_q.push_back(d);
    tick();
    wb0_valid = 1'b0;
    wait_drain(5, "enq_wake_miss");
    idle();
  endtask

  task automatic test_full();
    logic [DW-1:0] d;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      checks++; if (can_enq !== 1'b1) begin errors++; $display("FAIL full_fill_can_enq_%0d: got %b expected 1", k, can_enq); end
      tick();
      d = mk(7'(20 + k), 6'd0, 6'd0, 1'b0, 1'b0);
      enq_valid = 1'b1; enq_data = d; enq_cond = 2'b00; exu_ready = 1'b0;
      exp_q.push_back(d);
    end
    tick();
    enq_data = mk(7'd99, 6'd0, 6'd0, 1'b0, 1'b0);
    @(negedge clock);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", count); end
    checks++; if (can_enq !== 1'b0) begin errors++; $display("FAIL full_can_enq: got %b expected 0", can_enq); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_enq_ready: got %b expected 0", enq_ready); end
    tick();
    @(negedge clock);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_hold_count: got %0d expected 8", count); end
    tick();
    enq_valid = 1'b0; exu_ready = 1'b1;
    tick();
    exu_ready = 1'b0;
    @(negedge clock);
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_after_issue_count: got %0d expected 7", count); end
    checks++; if (can_enq !== 1'b1) begin errors++; $display("FAIL full_after_issue_can_enq: got %b expected 1", can_enq); end
    tick();
    exu_ready = 1'b1;
    wait_drain(20, "full");
    @(negedge clock);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL full_drained_count: got %0d expected 0", count); end
    tick();
    idle();
  endtask

  task automatic test_order();
    logic [DW-1:0] a, b, c;
    tick();
    a = mk(7'd40, 6'd9, 6'd0, 1'b1, 1'b0);
    b = mk(7'd41, 6'd0, 6'd0, 1'b0, 1'b0);
    c = mk(7'd42, 6'd0, 6'd0, 1'b0, 1'b0);
    enq_valid = 1'b1; enq_data = a; enq_cond = 2'b01; exu_ready = 1'b0;
    tick();
    enq_data = b; enq_cond = 2'b00; exp_q.push_back(b);
    tick();
    enq_data = c; exp_q.push_back(c);
    tick();
    enq_valid = 1'b0; exu_ready = 1'b1;
    @(negedge clock);
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL order_count3: got %0d expected 3", count); end
    tick();
    @(negedge clock);
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL order_count2: got %0d expected 2", count); end
    tick();
    @(negedge clock);
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL order_sleeper_held: got %b expected 0", issue_valid); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL order_count1: got %0d expected 1", count); end
    tick();
    wb0_valid = 1'b1; wb0_prd = 6'd9;
    exp_q.push_back(a);
    tick();
    wb0_valid = 1'b0;
    wait_drain(5, "order");
    idle();
  endtask

  task automatic test_shift_wake();
    logic [DW-1:0] r, s;
    tick();
    r = mk(7'd50, 6'd0, 6'd0, 1'b0, 1'b0);
    s = mk(7'd51, 6'd13, 6'd0, 1'b1, 1'b0);
    enq_valid = 1'b1; enq_data = r; enq_cond = 2'b00; exu_ready = 1'b0;
    exp_q.push_back(r);
    tick();
    enq_data = s; enq_cond = 2'b01;
    tick();
    enq_valid = 1'b0; exu_ready = 1'b1;
    wb0_valid = 1'b1; wb0_prd = 6'd13;
    exp_q.push_back(s);
    tick();
    wb0_valid = 1'b0;
    @(negedge clock);
    checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL shift_wake: got %b expected 1", issue_valid); end
    wait_drain(5, "shift_wake");
    idle();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    for (int k = 0; k < 10; k++) begin
      tick();
      d = mk(7'(80 + k), 6'd0, 6'd0, 1'b0, 1'b0);
      enq_valid = 1'b1; enq_data = d; enq_cond = 2'b00; exu_ready = 1'b1;
      exp_q.push_back(d);
      @(negedge clock);
      if (k >= 1) begin
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL b2b_count_%0d: got %0d expected 1", k, count); end
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL b2b_issue_valid_%0d: got %b expected 1", k, issue_valid); end
      end
    end
    tick();
    enq_valid = 1'b0;
    wait_drain(5, "b2b");
    idle();
  endtask

  task automatic test_flush();
    for (int k = 0; k < 5; k++) begin
      tick();
      enq_valid = 1'b1; enq_data = mk(7'(60 + k), 6'd0, 6'd0, 1'b0, 1'b0); enq_cond = 2'b00;
      exu_ready = 1'b0;
    end
    tick();
    enq_valid = 1'b0;
    @(negedge clock);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_pre_count: got %0d expected 5", count); end
    tick();
    flush = 1'b1; enq_valid = 1'b1; enq_data = mk(7'd70, 6'd0, 6'd0, 1'b0, 1'b0); exu_ready = 1'b1;
    @(negedge clock);
    checks++; if (can_enq !== 1'b0) begin errors++; $display("FAIL flush_can_enq: got %b expected 0", can_enq); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_issue_valid: got %b expected 0", issue_valid); end
    tick();
    flush = 1'b0; enq_valid = 1'b0;
    @(negedge clock);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_post_issue_valid: got %b expected 0", issue_valid); end
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      tick();
      enq_valid = 1'b1; enq_data = mk(7'(90 + k), 6'd0, 6'd0, 1'b0, 1'b0); enq_cond = 2'b00;
      exu_ready = 1'b0;
    end
    tick();
    enq_valid = 1'b0;
    @(negedge clock);
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL rstmid_pre_count: got %0d expected 3", count); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", count); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL rstmid_issue_valid: got %b expected 0", issue_valid); end
    checks++; if (can_enq !== 1'b1) begin errors++; $display("FAIL rstmid_can_enq: got %b expected 1", can_enq); end
    tick();
    reset_n = 1'b1;
    exu_ready = 1'b1;
    @(negedge clock);
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL rstmid_post_issue_valid: got %b expected 0", issue_valid); end
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_same_cycle_wake();
    test_full();
    test_order();
    test_shift_wake();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
